// File: rtl/sram_pkg.sv
// sram_pkg -- shared types and constants for the off-chip SRAM bus responder.
//
// Contents:
//   SRAM_DATA_W / SRAM_ADDR_W : external bus widths (16-bit data, 18-bit word address)
//   access_kind_t             : per-edge bus cycle classification (IDLE, READ, WRITE)
//   lane_mask_t               : active-low byte-lane enables as sampled {ub, lb}
//   read_entry_t              : one read in flight {valid, data, mask}
//   classify()                : maps the active-low controls onto an access kind
package sram_pkg;

   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } access_kind_t;

   typedef struct packed {
      logic ub;
      logic lb;
   } lane_mask_t;

   typedef struct packed {
      logic                   valid;
      logic [SRAM_DATA_W-1:0] data;
      lane_mask_t             mask;
   } read_entry_t;

   // WE dominates OE, so a cycle with both asserted is treated as a write.
   function automatic access_kind_t classify(input logic ce_n, input logic we_n,
                                             input logic oe_n);
      access_kind_t kind;
      kind = IDLE;
      if (!ce_n) begin
         if (!we_n) begin
            kind = WRITE;
         end else if (!oe_n) begin
            kind = READ;
         end
      end
      return kind;
   endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// sram_read_pipe -- fixed-depth delay line for reads in flight.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low clear of every valid bit
//   in_entry  : entry shifted into the head each edge
//   tail      : oldest entry (DEPTH edges after it entered)
//   any_valid : OR of all stage valid bits
//
// Only the valid bits are cleared; data and mask are don't-care while invalid.
module sram_read_pipe
   import sram_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  read_entry_t in_entry,
   output read_entry_t tail,
   output logic        any_valid
);

   logic                   valid_reg [DEPTH];
   logic [SRAM_DATA_W-1:0] data_reg  [DEPTH];
   lane_mask_t             mask_reg  [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_reg[gi] <= 1'b0;
            end else begin
               valid_reg[gi] <= in_entry.valid;
            end
         end

         always_ff @(posedge clk) begin
            data_reg[gi] <= in_entry.data;
            mask_reg[gi] <= in_entry.mask;
         end
      end else begin : g_body
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_reg[gi] <= 1'b0;
            end else begin
               valid_reg[gi] <= valid_reg[gi-1];
            end
         end

         always_ff @(posedge clk) begin
            data_reg[gi] <= data_reg[gi-1];
            mask_reg[gi] <= mask_reg[gi-1];
         end
      end
   end

   assign tail.valid = valid_reg[DEPTH-1];
   assign tail.data  = data_reg[DEPTH-1];
   assign tail.mask  = mask_reg[DEPTH-1];

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_valid = any_valid | valid_reg[i];
      end
   end

endmodule

// File: rtl/sram_responder.sv
// sram_responder -- behavioural-timing responder for the 16-bit asynchronous
// SRAM bus, with byte-lane writes, pipelined read return and access counters.
//
// Parameters:
//   DEPTH_LOG2   : storage is 2**DEPTH_LOG2 x 16 (4..18); upper address bits alias
//   READ_LATENCY : edges from read sample to data drive (1..4)
//
// Ports:
//   clk           : clock, rising edge samples everything
//   rst           : asynchronous active-low reset (storage is not reset)
//   SRAMData      : shared tri-state data bus, driven only when returning a read
//   SRAMAddress   : word address
//   SRAMUB/SRAMLB : active-low upper/lower byte enables
//   SRAMWE/SRAMOE : active-low write / output enables
//   SRAMCE        : active-low chip enable
//   readCount     : sampled reads, wraps at 2**16
//   writeCount    : sampled writes, wraps at 2**16
//   busy          : a read is somewhere between sampling and delivery
//   protocolError : sticky protocol violation flag
//
// Build option: define SRAM_RESP_CHECK_EN to build the protocol checker;
// otherwise protocolError is constant 0.
module sram_responder
   import sram_pkg::*;
#(
   parameter int DEPTH_LOG2   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   inout  wire  [SRAM_DATA_W-1:0] SRAMData,
   input  logic [SRAM_ADDR_W-1:0] SRAMAddress,
   input  logic                   SRAMUB,
   input  logic                   SRAMLB,
   input  logic                   SRAMWE,
   input  logic                   SRAMOE,
   input  logic                   SRAMCE,
   output logic [15:0]            readCount,
   output logic [15:0]            writeCount,
   output logic                   busy,
   output logic                   protocolError
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   access_kind_t           kind;
   logic [DEPTH_LOG2-1:0]  idx;
   logic                   read_ctrl;

   logic [SRAM_DATA_W-1:0] mem [DEPTH];

   // Sample stage: the registered storage read plus its valid/mask. Together
   // with the READ_LATENCY-deep pipe behind it, data appears READ_LATENCY
   // edges after the sample edge.
   logic                   rd_valid_reg;
   logic [SRAM_DATA_W-1:0] rd_data_reg;
   lane_mask_t             rd_mask_reg;

   logic [15:0]            read_count_reg;
   logic [15:0]            write_count_reg;

   read_entry_t            pipe_in;
   read_entry_t            pipe_tail;
   logic                   pipe_any_valid;

   assign kind      = classify(SRAMCE, SRAMWE, SRAMOE);
   assign idx       = SRAMAddress[DEPTH_LOG2-1:0];
   assign read_ctrl = !SRAMCE && SRAMWE && !SRAMOE;

   // Storage: byte-lane writes, registered read. Not reset.
   always_ff @(posedge clk) begin
      if (kind == WRITE) begin
         if (!SRAMLB) begin
            mem[idx][7:0] <= SRAMData[7:0];
         end
         if (!SRAMUB) begin
            mem[idx][15:8] <= SRAMData[15:8];
         end
      end
      rd_data_reg <= mem[idx];
      rd_mask_reg <= '{ub: SRAMUB, lb: SRAMLB};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_reg    <= 1'b0;
         read_count_reg  <= '0;
         write_count_reg <= '0;
      end else begin
         rd_valid_reg <= (kind == READ);
         if (kind == READ) begin
            read_count_reg <= read_count_reg + 16'd1;
         end
         if (kind == WRITE) begin
            write_count_reg <= write_count_reg + 16'd1;
         end
      end
   end

   assign pipe_in.valid = rd_valid_reg;
   assign pipe_in.data  = rd_data_reg;
   assign pipe_in.mask  = rd_mask_reg;

   sram_read_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_entry  (pipe_in),
      .tail      (pipe_tail),
      .any_valid (pipe_any_valid)
   );

   // Each lane is driven only while the bus currently looks like a read;
   // otherwise the tail word simply falls off the end of the pipe.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic lane_off;
      assign lane_off = (gi == 0) ? pipe_tail.mask.lb : pipe_tail.mask.ub;
      assign SRAMData[gi*8 +: 8] = (pipe_tail.valid && read_ctrl && !lane_off)
                                   ? pipe_tail.data[gi*8 +: 8] : 8'hzz;
   end

   assign readCount  = read_count_reg;
   assign writeCount = write_count_reg;
   // All sources are flops, so busy is glitch-free in practice.
   assign busy       = rd_valid_reg | pipe_any_valid;

`ifdef SRAM_RESP_CHECK_EN
   logic violation;
   logic addr_high;
   logic protocol_error_reg;

   assign addr_high = (SRAMAddress >> DEPTH_LOG2) != '0;

   always_comb begin
      violation = 1'b0;
      if (!SRAMCE && !SRAMWE && !SRAMOE) begin
         violation = 1'b1;
      end
      if (!SRAMCE && SRAMUB && SRAMLB && (!SRAMWE || !SRAMOE)) begin
         violation = 1'b1;
      end
      if ((kind == READ || kind == WRITE) && addr_high) begin
         violation = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         protocol_error_reg <= 1'b0;
      end else if (violation) begin
         protocol_error_reg <= 1'b1;
      end
   end

   assign protocolError = protocol_error_reg;
`else
   logic unused_addr_bits;
   assign unused_addr_bits = |(SRAMAddress >> DEPTH_LOG2);
   assign protocolError    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder -- table-driven bench for sram_responder. Two instances
// (READ_LATENCY 1 and 3, DEPTH_LOG2 10) share the control inputs; each has
// its own pulled-up data bus so an undriven lane reads back as 8'hFF.
// Expected read words come from the vector table and are queued per instance
// with their due edge; they are popped and compared when due.
module tb_sram_responder;
   import sram_pkg::*;

`ifdef SRAM_RESP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   logic        ce = 1'b1, we = 1'b1, oe = 1'b1, ub = 1'b1, lb = 1'b1;
   logic [17:0] addr = '0;
   logic [15:0] wd = '0;
   logic        tb_drv = 1'b0;

   wire [15:0] bus1;
   wire [15:0] bus3;
   assign bus1 = tb_drv ? wd : 16'hzzzz;
   assign bus3 = tb_drv ? wd : 16'hzzzz;
   for (genvar gi = 0; gi < 16; gi++) begin : g_pull
      pullup (bus1[gi]);
      pullup (bus3[gi]);
   end

   logic [15:0] rc1, wc1, rc3, wc3;
   logic        busy1, busy3, perr1, perr3;

   sram_responder #(.DEPTH_LOG2(10), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .SRAMData(bus1), .SRAMAddress(addr),
      .SRAMUB(ub), .SRAMLB(lb), .SRAMWE(we), .SRAMOE(oe), .SRAMCE(ce),
      .readCount(rc1), .writeCount(wc1), .busy(busy1), .protocolError(perr1));

   sram_responder #(.DEPTH_LOG2(10), .READ_LATENCY(3)) u_lat3 (
      .clk(clk), .rst(rst), .SRAMData(bus3), .SRAMAddress(addr),
      .SRAMUB(ub), .SRAMLB(lb), .SRAMWE(we), .SRAMOE(oe), .SRAMCE(ce),
      .readCount(rc3), .writeCount(wc3), .busy(busy3), .protocolError(perr3));

   typedef struct {
      logic        rst_before;
      logic        ce, we, oe, ub, lb;
      logic [17:0] a;
      logic [15:0] w;
      logic [15:0] e;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] data;
      logic [1:0]  mask;
   } exp_t;

   localparam int NV = 32;
   vec_t vecs [NV];
   exp_t q1[$];
   exp_t q3[$];

   int          total = 0;
   int          bad = 0;
   logic [15:0] m_rc = '0;
   logic [15:0] m_wc = '0;
   logic        m_perr = 1'b0;

   function automatic vec_t mk(logic r, logic c, logic w_n, logic o, logic u, logic l,
                               logic [17:0] a, logic [15:0] w, logic [15:0] e);
      vec_t v;
      v.rst_before = r; v.ce = c; v.we = w_n; v.oe = o; v.ub = u; v.lb = l;
      v.a = a; v.w = w; v.e = e;
      return v;
   endfunction

   function automatic logic [15:0] bus_exp(vec_t v, bit hit, exp_t e);
      logic [15:0] r;
      r = 16'hFFFF;
      if (!v.we) begin
         r = v.w;
      end else if (hit && !v.ce && !v.oe) begin
         r[15:8] = e.mask[1] ? 8'hFF : e.data[15:8];
         r[7:0]  = e.mask[0] ? 8'hFF : e.data[7:0];
      end
      return r;
   endfunction

   task automatic check(string name, int idx, logic [15:0] act, logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
      end
   endtask

   task automatic check_status(int idx, bit b1, bit b3);
      check("readCount_l1", idx, rc1, m_rc);
      check("writeCount_l1", idx, wc1, m_wc);
      check("readCount_l3", idx, rc3, m_rc);
      check("writeCount_l3", idx, wc3, m_wc);
      check("busy_l1", idx, {15'd0, busy1}, {15'd0, b1});
      check("busy_l3", idx, {15'd0, busy3}, {15'd0, b3});
      check("perr_l1", idx, {15'd0, perr1}, {15'd0, CHK & m_perr});
      check("perr_l3", idx, {15'd0, perr3}, {15'd0, CHK & m_perr});
   endtask

   task automatic apply(int idx);
      vec_t v;
      exp_t e1, e3;
      bit   hit1, hit3, viol;
      v = vecs[idx];
      @(negedge clk);
      ce = v.ce; we = v.we; oe = v.oe; ub = v.ub; lb = v.lb;
      addr = v.a; wd = v.w; tb_drv = !v.we;
      @(posedge clk);
      #1;
      // model update for the edge just sampled (edge_n now counts it)
      viol = (!v.ce && !v.we && !v.oe) || (!v.ce && v.ub && v.lb && (!v.we || !v.oe)) ||
             (!v.ce && (!v.we || !v.oe) && (v.a[17:10] != 8'd0));
      if (viol) m_perr = 1'b1;
      if (!v.ce && !v.we) begin
         m_wc = m_wc + 16'd1;
      end else if (!v.ce && !v.oe) begin
         m_rc = m_rc + 16'd1;
         q1.push_back('{due: edge_n + 1, data: v.e, mask: {v.ub, v.lb}});
         q3.push_back('{due: edge_n + 3, data: v.e, mask: {v.ub, v.lb}});
      end
      e1 = '{due: 0, data: '0, mask: '0};
      e3 = '{due: 0, data: '0, mask: '0};
      hit1 = (q1.size() > 0) && (q1[0].due == edge_n);
      hit3 = (q3.size() > 0) && (q3[0].due == edge_n);
      if (hit1) e1 = q1.pop_front();
      if (hit3) e3 = q3.pop_front();
      check("bus_l1", idx, bus1, bus_exp(v, hit1, e1));
      check("bus_l3", idx, bus3, bus_exp(v, hit3, e3));
      check_status(idx, hit1 || (q1.size() > 0), hit3 || (q3.size() > 0));
      $display("vec %0d ce=%b we=%b oe=%b ub=%b lb=%b addr=%h bus1=%h bus3=%h rc=%0d wc=%0d",
               idx, v.ce, v.we, v.oe, v.ub, v.lb, v.a, bus1, bus3, rc1, wc1);
   endtask

   // Asserted mid-cycle with the previous controls still on the bus.
   task automatic do_reset(int idx);
      #2;
      rst = 1'b0;
      #1;
      m_rc = '0; m_wc = '0; m_perr = 1'b0;
      q1.delete();
      q3.delete();
      check("rst_bus_l1", idx, bus1, 16'hFFFF);
      check("rst_bus_l3", idx, bus3, 16'hFFFF);
      check_status(idx, 1'b0, 1'b0);
      $display("reset before vec %0d bus1=%h bus3=%h", idx, bus1, bus3);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; oe = 1'b1; ub = 1'b1; lb = 1'b1; tb_drv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      //             rst ce we oe ub lb addr       wdata     expected
      vecs[0]  = mk(0, 0, 0, 1, 0, 0, 18'h00010, 16'hBEEF, 16'h0000);
      vecs[1]  = mk(0, 0, 1, 0, 0, 0, 18'h00010, 16'h0000, 16'hBEEF);
      vecs[2]  = mk(0, 0, 1, 0, 0, 0, 18'h00010, 16'h0000, 16'hBEEF);
      vecs[3]  = mk(1, 0, 0, 1, 0, 0, 18'h00020, 16'h1234, 16'h0000);
      vecs[4]  = mk(0, 0, 0, 1, 0, 1, 18'h00020, 16'hAB00, 16'h0000);
      vecs[5]  = mk(0, 0, 1, 0, 0, 0, 18'h00020, 16'h0000, 16'hAB34);
      vecs[6]  = mk(0, 0, 1, 0, 1, 0, 18'h00020, 16'h0000, 16'hAB34);
      vecs[7]  = mk(0, 0, 0, 1, 0, 0, 18'h00400, 16'h5555, 16'h0000);
      vecs[8]  = mk(0, 0, 1, 0, 0, 0, 18'h00000, 16'h0000, 16'h5555);
      vecs[9]  = mk(0, 0, 0, 1, 0, 0, 18'h00000, 16'h6666, 16'h0000);
      vecs[10] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[11] = mk(0, 0, 1, 0, 0, 0, 18'h00000, 16'h0000, 16'h6666);
      vecs[12] = mk(0, 0, 1, 0, 0, 0, 18'h00000, 16'h0000, 16'h6666);
      vecs[13] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[14] = mk(0, 0, 1, 0, 0, 0, 18'h00010, 16'h0000, 16'hBEEF);
      vecs[15] = mk(0, 0, 1, 1, 0, 0, 18'h00010, 16'h0000, 16'h0000);
      vecs[16] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[17] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[18] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[19] = mk(1, 0, 0, 0, 0, 0, 18'h00030, 16'h0F0F, 16'h0000);
      vecs[20] = mk(0, 0, 0, 1, 1, 1, 18'h00030, 16'hAAAA, 16'h0000);
      vecs[21] = mk(0, 0, 1, 0, 0, 0, 18'h00030, 16'h0000, 16'h0F0F);
      vecs[22] = mk(0, 0, 1, 0, 0, 0, 18'h00030, 16'h0000, 16'h0F0F);
      vecs[23] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[24] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[25] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[26] = mk(1, 0, 1, 0, 0, 0, 18'h00400, 16'h0000, 16'h6666);
      vecs[27] = mk(0, 0, 1, 0, 0, 0, 18'h00000, 16'h0000, 16'h6666);
      vecs[28] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[29] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[30] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);
      vecs[31] = mk(0, 1, 1, 1, 1, 1, 18'h00000, 16'h0000, 16'h0000);

      // power-on reset state
      repeat (2) @(posedge clk);
      #1;
      check("por_bus_l1", -1, bus1, 16'hFFFF);
      check("por_bus_l3", -1, bus3, 16'hFFFF);
      check_status(-1, 1'b0, 1'b0);
      $display("power-on reset bus1=%h bus3=%h rc=%0d wc=%0d", bus1, bus3, rc1, wc1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst_before) do_reset(i);
         apply(i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the run gets stuck somewhere.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the 16-bit off-chip asynchronous SRAM bus that the memory stage drives. It models the external SRAM device, 256K×16 pin-compatible and with a configurable depth, on the bench and in on-chip test builds. It samples the active-low SRAM controls every clock, performs byte-lane writes into internal storage, and returns read data on the shared tri-state bus after a fixed pipeline latency. It also maintains access counters for the pipeline-freeze and memory tests.

## Interface
Parameters:
- DEPTH_LOG2, 10: storage is 2**DEPTH_LOG2 words of 16 bits. Legal range is 4..18.
- READ_LATENCY, 1: clock edges from a read being sampled to its data being driven. Legal range is 1..4.

Ports:
- clk, input, 1: the single clock. All sampling happens on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- SRAMData, inout, 16: shared data bus. This block drives it only when delivering a read; otherwise it is Z.
- SRAMAddress, input, 18: word address.
- SRAMUB, input, 1: upper-byte enable, active-low.
- SRAMLB, input, 1: lower-byte enable, active-low.
- SRAMWE, input, 1: write enable, active-low.
- SRAMOE, input, 1: output enable, active-low.
- SRAMCE, input, 1: chip enable, active-low.
- readCount, output, 16: count of sampled reads, wrapping modulo 2**16.
- writeCount, output, 16: count of sampled writes, wrapping modulo 2**16.
- busy, output, 1: at least one read is in flight in the pipeline.
- protocolError, output, 1: sticky protocol-violation flag. See Configuration.

## Operation
- Each rising edge classifies the bus cycle into exactly one of three kinds:
  - IDLE: SRAMCE=1, or SRAMCE=0 with SRAMWE=1 and SRAMOE=1.
  - WRITE: SRAMCE=0 and SRAMWE=0. SRAMWE dominates SRAMOE.
  - READ: SRAMCE=0, SRAMWE=1 and SRAMOE=0.
- Address index is SRAMAddress[DEPTH_LOG2-1:0]. Upper bits are ignored, so addresses alias modulo the depth.
- WRITE behaviour:
  - SRAMLB=0 updates bits [7:0] from SRAMData.
  - SRAMUB=0 updates bits [15:8] from SRAMData.
  - A write with both lanes disabled changes no storage but still increments writeCount.
- READ behaviour:
  - The storage word and the lane mask {UB,LB} are captured at the sample edge and enter the latency pipeline.
  - Every held cycle is a new sample. A read held for N edges issues N reads and adds N to readCount.
- Delivery: when the pipeline tail is valid, SRAMData is driven combinationally only while SRAMCE=0, SRAMWE=1 and SRAMOE=0 hold currently.
  - Lanes whose captured mask bit was 1 stay Z.
  - If those control conditions are not met, the whole bus is Z and the delivered word is discarded.
- Ordering:
  - A write at edge N is visible to a read sampled at edge N+1 or later.
  - A read already in flight returns the data captured at its sample edge, even if the word is written before delivery.
- Memory contents are not reset. They are X until written.

## Timing
- Read data is valid from just after edge S+READ_LATENCY until edge S+READ_LATENCY+1, where S is the sample edge.
- Back-to-back reads stream one word per cycle with no bubbles.
- Write latency is 0. Storage updates at the sample edge.
- readCount and writeCount update at the sample edge.
- busy is the OR of the pipeline valid bits, registered.
- Reset, including asserted mid-operation:
  - Asynchronously clears all pipeline valid bits, so SRAMData goes Z immediately.
  - Sets readCount=0, writeCount=0, busy=0 and protocolError=0.
  - Storage is untouched.
- The first edge after rst rises samples normally.

## Configuration
- SRAM_RESP_CHECK_EN defined enables the protocol checker. protocolError sets at any edge that sees any of:
  - SRAMCE=0, SRAMWE=0 and SRAMOE=0 together (bus contention).
  - SRAMCE=0 with SRAMUB=1, SRAMLB=1 and either SRAMWE=0 or SRAMOE=0.
  - A READ or WRITE whose SRAMAddress bits above DEPTH_LOG2-1 are nonzero.
- protocolError clears only on reset. Violating cycles are still executed as classified above.
- SRAM_RESP_CHECK_EN undefined: protocolError is tied 0 and no checker logic is built.

## Structure
- Shared package sram_pkg holds:
  - SRAM_DATA_W=16 and SRAM_ADDR_W=18.
  - An access-kind enum: IDLE, READ, WRITE.
  - A lane-mask typedef {ub,lb}.
  - A read-pipe entry struct {valid, data, mask}.
- One sub-module, sram_read_pipe: a READ_LATENCY-deep shift register of entries with asynchronous active-low clear, exposing its tail entry and the OR of its valid bits.

## Test plan
- Reset: pulse rst low mid-stream -> SRAMData=Z at once; readCount=0, writeCount=0, busy=0, protocolError=0.
- Write then read (READ_LATENCY=1):
  - Stimulus: write 0xBEEF to 0x00010 with both lanes enabled, then hold a read for 2 edges.
  - Response: SRAMData=0xBEEF after each read edge; readCount=2, writeCount=1.
- Byte lanes:
  - Write 0x1234 with both lanes to an address, then write 0xAB00 with SRAMLB=1 to the same address.
  - A full read returns 0xAB34.
  - A read with SRAMUB=1 gives upper byte Z and lower byte 0x34.
- Latency (READ_LATENCY=3):
  - A single-edge read with controls held delivers data exactly after the 3rd edge; busy=1 for the 3 cycles before delivery.
  - Raising SRAMOE before delivery gives Z.
- Aliasing and ordering (DEPTH_LOG2=10):
  - Write 0x5555 to 0x00400; a read of 0x00000 returns 0x5555.
  - A write of 0x6666 to 0x00000 issued while a read of 0x00000 is in flight still lets that read return 0x5555.
- Checker (with SRAM_RESP_CHECK_EN):
  - SRAMCE=0, SRAMWE=0, SRAMOE=0 for one edge -> protocolError=1 sticky until reset, and the write is performed.
  - A read of 0x00400 with DEPTH_LOG2=10 also sets protocolError.
